// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared opcodes, state encoding and instruction field positions for the register-file sequencer.
package rf_seq_pkg;

    localparam int DATA_W  = 8;
    localparam int SEL_W   = 4;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_LDI = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RA_HI  = 7;
    localparam int RA_LO  = 4;
    localparam int RB_HI  = 3;
    localparam int RB_LO  = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    function automatic logic is_write_op(input logic [3:0] op);
        return op >= OP_ADD && op <= OP_NOT;
    endfunction

endpackage

// File: rtl/rf_instr_sequencer_if.sv
// rf_instr_sequencer_if: instruction handshake plus register-file read/write bus of the sequencer.
interface rf_instr_sequencer_if;
    import rf_seq_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  rf_a;
    logic [DATA_W-1:0]  rf_b;
    logic [SEL_W-1:0]   a_sel;
    logic [SEL_W-1:0]   b_sel;
    logic [SEL_W-1:0]   wr_sel;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_en;

    modport master (
        output instr_valid, instr, rf_a, rf_b,
        input  instr_ready, a_sel, b_sel, wr_sel, wr_data, wr_en
    );

    modport slave (
        input  instr_valid, instr, rf_a, rf_b,
        output instr_ready, a_sel, b_sel, wr_sel, wr_data, wr_en
    );

endinterface

// File: rtl/rf_seq_alu.sv
// rf_seq_alu: combinational ALU; carry is the ADD carry-out or the SUB borrow.
module rf_seq_alu
    import rf_seq_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm8,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: {carry, result} = sum;
            OP_SUB: {carry, result} = diff;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_MOV: result = a;
            OP_LDI: result = imm8;
            OP_NOT: result = ~a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rf_instr_sequencer.sv
// rf_instr_sequencer: three-cycle IDLE/EXEC/WB sequencer driving the 16x8 register file.
// Define R15_WRITE_PROTECT_EN to make writes to r15 illegal.
module rf_instr_sequencer
    import rf_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    rf_instr_sequencer_if.slave  bus,
    output logic                 done,
    output logic                 zero_flag,
    output logic                 carry_flag,
    output logic                 illegal_err
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [SEL_W-1:0]   a_sel_q, a_sel_d, b_sel_q, b_sel_d, wr_sel_q, wr_sel_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               we_q, we_d, zero_q, zero_d, carry_q, carry_d, ill_q, ill_d;

    logic [3:0]         op;
    logic [SEL_W-1:0]   rd;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_carry;
    logic               wr_op;
    logic               protect;

    assign op    = instr_q[OP_HI:OP_LO];
    assign rd    = instr_q[RD_HI:RD_LO];
    assign wr_op = is_write_op(op);

`ifdef R15_WRITE_PROTECT_EN
    assign protect = wr_op && rd == 4'hF;
`else
    assign protect = 1'b0;
`endif

    rf_seq_alu u_alu (
        .op     (op),
        .a      (bus.rf_a),
        .b      (bus.rf_b),
        .imm8   (instr_q[IMM_HI:IMM_LO]),
        .result (alu_res),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        a_sel_d   = a_sel_q;
        b_sel_d   = b_sel_q;
        wr_sel_d  = wr_sel_q;
        wr_data_d = wr_data_q;
        we_d      = we_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        ill_d     = ill_q;
        case (state_q)
            // Selects are loaded on acceptance so they are already valid throughout EXEC.
            S_IDLE: if (bus.instr_valid) begin
                instr_d = bus.instr;
                a_sel_d = bus.instr[RA_HI:RA_LO];
                b_sel_d = bus.instr[RB_HI:RB_LO];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                wr_data_d = alu_res;
                wr_sel_d  = rd;
                we_d      = wr_op && !protect;
                zero_d    = we_d ? alu_res == '0 : zero_q;
                carry_d   = we_d && (op == OP_ADD || op == OP_SUB) ? alu_carry : carry_q;
                ill_d     = ill_q || op > OP_NOT || protect;
                state_d   = S_WB;
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            a_sel_q   <= '0;
            b_sel_q   <= '0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
            we_q      <= 1'b0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            a_sel_q   <= a_sel_d;
            b_sel_q   <= b_sel_d;
            wr_sel_q  <= wr_sel_d;
            wr_data_q <= wr_data_d;
            we_q      <= we_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            ill_q     <= ill_d;
        end
    end

    assign bus.instr_ready = state_q == S_IDLE && !rst;
    assign bus.a_sel       = a_sel_q;
    assign bus.b_sel       = b_sel_q;
    assign bus.wr_sel      = wr_sel_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.wr_en       = state_q == S_WB && we_q;
    assign done            = state_q == S_WB;
    assign zero_flag       = zero_q;
    assign carry_flag      = carry_q;
    assign illegal_err     = ill_q;

endmodule

// File: tb/tb_rf_instr_sequencer.sv
// tb_rf_instr_sequencer: directed and random checks of the sequencer against an instruction-level model.
module tb_rf_instr_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done, zero_flag, carry_flag, illegal_err;
    logic rf_load = 1'b1;
    logic [7:0] rf [16];

    int checks = 0;
    int failures = 0;

    logic [7:0] ref_rf [16];
    bit ref_zero, ref_carry, ref_ill;
    bit exp_we;
    logic [3:0] exp_sel;
    logic [7:0] exp_data;

    rf_instr_sequencer_if bus();

    rf_instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .done        (done),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .illegal_err (illegal_err)
    );

    always #5 clk = ~clk;

    assign bus.rf_a = rf[bus.a_sel];
    assign bus.rf_b = rf[bus.b_sel];

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'hF0;
        end else if (bus.wr_en) begin
            rf[bus.wr_sel] <= bus.wr_data;
        end
    end

    // Instruction-level model: architectural effect of one instruction.
    task automatic predict(input logic [15:0] ins);
        int op, rd, a, b, r;
        bit wr, prot;
        op = int'(ins[15:12]);
        rd = int'(ins[11:8]);
        a  = int'(ref_rf[ins[7:4]]);
        b  = int'(ref_rf[ins[3:0]]);
        case (op)
            1: r = a + b;
            2: r = a - b;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = a;
            7: r = int'(ins[7:0]);
            8: r = 255 - a;
            default: r = 0;
        endcase
        wr = op >= 1 && op <= 8;
`ifdef R15_WRITE_PROTECT_EN
        prot = wr && rd == 15;
`else
        prot = 1'b0;
`endif
        exp_we  = wr && !prot;
        exp_sel = ins[11:8];
        if (op > 8 || prot) ref_ill = 1'b1;
        if (exp_we) begin
            exp_data = 8'((r + 256) % 256);
            ref_rf[rd] = exp_data;
            ref_zero = exp_data == 8'h00;
            if (op == 1) ref_carry = r > 255;
            if (op == 2) ref_carry = r < 0;
        end
    endtask

    // Presents one instruction, returns #1 into its WB cycle.
    task automatic send(input logic [15:0] ins);
        int n = 0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = ins;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.instr_ready) begin
            failures++;
            $display("FAIL accept_timeout ready=%b required=1", bus.instr_ready);
        end
        @(posedge clk);
        predict(ins);
        #1 bus.instr_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        rst = 1'b1;
        rf_load = 1'b1;
        for (int i = 0; i < 16; i++) ref_rf[i] = 8'hF0;
        ref_zero = 0; ref_carry = 0; ref_ill = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.instr_ready, bus.wr_en, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl ready/wr_en/done=%b required=000", {bus.instr_ready, bus.wr_en, done});
        end
        checks++;
        if ({zero_flag, carry_flag, illegal_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b required=000", {zero_flag, carry_flag, illegal_err});
        end
        checks++;
        if ({bus.a_sel, bus.b_sel, bus.wr_sel, bus.wr_data} !== 20'h0) begin
            failures++;
            $display("FAIL reset_bus got=%h required=00000", {bus.a_sel, bus.b_sel, bus.wr_sel, bus.wr_data});
        end
        @(negedge clk);
        rf_load = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b required=1", bus.instr_ready);
        end
    endtask

    task automatic test_add();
        send(16'h1123);
        checks++;
        if ({bus.wr_en, done, bus.wr_sel, bus.wr_data} !== {1'b1, 1'b1, 4'h1, 8'hE0}) begin
            failures++;
            $display("FAIL add_wb wr_en=%b done=%b sel=%h data=%h required 1 1 1 e0", bus.wr_en, done, bus.wr_sel, bus.wr_data);
        end
        checks++;
        if ({carry_flag, zero_flag} !== 2'b10) begin
            failures++;
            $display("FAIL add_flags carry/zero=%b required=10", {carry_flag, zero_flag});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.instr_ready, done, bus.wr_en} !== 3'b100 || rf[1] !== 8'hE0) begin
            failures++;
            $display("FAIL add_retire ready/done/wr_en=%b rf1=%h required 100 e0", {bus.instr_ready, done, bus.wr_en}, rf[1]);
        end
    endtask

    task automatic test_sub_zero();
        send(16'h7405);
        send(16'h2544);
        checks++;
        if ({bus.wr_en, bus.wr_sel, bus.wr_data, zero_flag, carry_flag} !== {1'b1, 4'h5, 8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sub_zero wr_en=%b sel=%h data=%h zero=%b carry=%b required 1 5 00 1 0", bus.wr_en, bus.wr_sel, bus.wr_data, zero_flag, carry_flag);
        end
    endtask

    task automatic test_sub_wrap();
        send(16'h7601);
        send(16'h7702);
        send(16'h2867);
        checks++;
        if ({bus.wr_en, bus.wr_sel, bus.wr_data, zero_flag, carry_flag} !== {1'b1, 4'h8, 8'hFF, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL sub_wrap wr_en=%b sel=%h data=%h zero=%b carry=%b required 1 8 ff 0 1", bus.wr_en, bus.wr_sel, bus.wr_data, zero_flag, carry_flag);
        end
    endtask

    task automatic test_r15();
        send(16'h7F3C);
`ifdef R15_WRITE_PROTECT_EN
        checks++;
        if ({bus.wr_en, done, illegal_err} !== 3'b011) begin
            failures++;
            $display("FAIL r15_protect wr_en/done/ill=%b required=011", {bus.wr_en, done, illegal_err});
        end
`else
        checks++;
        if ({bus.wr_en, bus.wr_sel, bus.wr_data, illegal_err} !== {1'b1, 4'hF, 8'h3C, 1'b0}) begin
            failures++;
            $display("FAIL r15_write wr_en=%b sel=%h data=%h ill=%b required 1 f 3c 0", bus.wr_en, bus.wr_sel, bus.wr_data, illegal_err);
        end
`endif
        checks++;
        if ({zero_flag, carry_flag} !== {ref_zero, ref_carry}) begin
            failures++;
            $display("FAIL r15_flags got=%b required=%b", {zero_flag, carry_flag}, {ref_zero, ref_carry});
        end
    endtask

    task automatic test_illegal();
        send(16'hC000);
        checks++;
        if ({bus.wr_en, done, illegal_err} !== 3'b011) begin
            failures++;
            $display("FAIL illegal_op wr_en/done/ill=%b required=011", {bus.wr_en, done, illegal_err});
        end
        send(16'h0000);
        checks++;
        if ({bus.wr_en, done, illegal_err} !== 3'b011) begin
            failures++;
            $display("FAIL illegal_sticky_nop wr_en/done/ill=%b required=011", {bus.wr_en, done, illegal_err});
        end
        checks++;
        if ({zero_flag, carry_flag} !== {ref_zero, ref_carry}) begin
            failures++;
            $display("FAIL illegal_flags_hold got=%b required=%b", {zero_flag, carry_flag}, {ref_zero, ref_carry});
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [15:0] ins;
        for (int t = 0; t < 60; t++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            ins = {op, 12'($urandom)};
            send(ins);
            checks++;
            if (bus.wr_en !== exp_we || done !== 1'b1) begin
                failures++;
                $display("FAIL rand_wr_en ins=%h wr_en=%b done=%b required %b 1", ins, bus.wr_en, done, exp_we);
            end
            if (exp_we) begin
                checks++;
                if (bus.wr_sel !== exp_sel || bus.wr_data !== exp_data) begin
                    failures++;
                    $display("FAIL rand_wb ins=%h sel=%h data=%h required %h %h", ins, bus.wr_sel, bus.wr_data, exp_sel, exp_data);
                end
            end
            checks++;
            if ({zero_flag, carry_flag, illegal_err} !== {ref_zero, ref_carry, ref_ill}) begin
                failures++;
                $display("FAIL rand_flags ins=%h got=%b required=%b", ins, {zero_flag, carry_flag, illegal_err}, {ref_zero, ref_carry, ref_ill});
            end
            @(posedge clk);
            #1;
            checks++;
            if (rf[exp_sel] !== ref_rf[exp_sel] || done !== 1'b0) begin
                failures++;
                $display("FAIL rand_rf ins=%h r%0d=%h done=%b required %h 0", ins, exp_sel, rf[exp_sel], done, ref_rf[exp_sel]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] lst [4];
        int acc [4];
        int k = 0;
        int writes = 0;
        int cyc = 0;
        int stray = 0;
        lst = '{16'h7A11, 16'h7B22, 16'h7C33, 16'h7D44};
        acc = '{0, 0, 0, 0};
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = lst[0];
        while (k < 4 && cyc < 40) begin
            if (bus.wr_en) writes++;
            if (bus.instr_ready) begin
                acc[k] = cyc;
                if (k < 3) predict(lst[k]);
                k++;
            end
            if (k < 4) begin
                @(posedge clk);
                #1 bus.instr = lst[k];
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (k !== 4) begin
            failures++;
            $display("FAIL b2b_accepts got=%0d required=4", k);
        end
        checks++;
        if (writes !== 3) begin
            failures++;
            $display("FAIL b2b_writes got=%0d required=3", writes);
        end
        checks++;
        if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3 || acc[3] - acc[2] !== 3) begin
            failures++;
            $display("FAIL b2b_spacing gaps=%0d,%0d,%0d required=3,3,3", acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.instr_ready !== 1'b0 || bus.a_sel !== 4'h4) begin
            failures++;
            $display("FAIL b2b_exec ready=%b a_sel=%h required 0 4", bus.instr_ready, bus.a_sel);
        end
        rst = 1'b1;
        ref_zero = 0; ref_carry = 0; ref_ill = 0;
        #1;
        checks++;
        if ({bus.instr_ready, bus.wr_en, done, zero_flag, carry_flag, illegal_err} !== 6'b0) begin
            failures++;
            $display("FAIL midop_reset_ctrl got=%b required=000000", {bus.instr_ready, bus.wr_en, done, zero_flag, carry_flag, illegal_err});
        end
        checks++;
        if ({bus.a_sel, bus.b_sel, bus.wr_sel, bus.wr_data} !== 20'h0) begin
            failures++;
            $display("FAIL midop_reset_bus got=%h required=00000", {bus.a_sel, bus.b_sel, bus.wr_sel, bus.wr_data});
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.wr_en || done) stray++;
        end
        checks++;
        if (stray !== 0 || rf[13] !== ref_rf[13]) begin
            failures++;
            $display("FAIL midop_discard stray=%0d r13=%h required 0 %h", stray, rf[13], ref_rf[13]);
        end
        checks++;
        if (rf[10] !== 8'h11 || rf[11] !== 8'h22 || rf[12] !== 8'h33 || bus.instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_rf r10..12=%h %h %h ready=%b required 11 22 33 1", rf[10], rf[11], rf[12], bus.instr_ready);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_zero();
        test_sub_wrap();
        test_r15();
        test_illegal();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
